// File: rtl/wb_regfile.sv
// Write-back stage: selects load vs ALU data and commits it to a 32-entry register file.
// Two decode read ports and one debug port see same-cycle writes through a bypass.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_WB,
  input  logic              MemtoReg_WB,
  input  logic [DATA_W-1:0] ReadData_WB,
  input  logic [DATA_W-1:0] ALUOut_WB,
  input  logic [ADDR_W-1:0] WriteReg_WB,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData_WB,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wb_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [31:0]       wb_count_q, wb_count_d;
  logic              we_eff;

  assign WriteData_WB = MemtoReg_WB ? ReadData_WB : ALUOut_WB;
  // Index 0 is hard-wired to zero, so a write there is neither stored nor counted.
  assign we_eff       = RegWrite_WB && (WriteReg_WB != '0);

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] widx,
    input logic [DATA_W-1:0] wdata
  );
    if (idx == '0)                    return '0;
    else if (we && (idx == widx))     return wdata;
    else                              return stored;
  endfunction

  assign ReadData1 = read_port(ReadReg1, regs_q[ReadReg1], we_eff, WriteReg_WB, WriteData_WB);
  assign ReadData2 = read_port(ReadReg2, regs_q[ReadReg2], we_eff, WriteReg_WB, WriteData_WB);
  assign dbg_data  = read_port(dbg_addr, regs_q[dbg_addr], we_eff, WriteReg_WB, WriteData_WB);
  assign wb_count  = wb_count_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    if (we_eff) begin
      regs_d[WriteReg_WB] = WriteData_WB;
      wb_count_d          = wb_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is reset on purpose: a reset must clear every register immediately.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wb_count_q <= '0;
    end else begin
      // NOTE: non-blocking so all flops update together from pre-edge values.
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected values, a negedge monitor
// pops and compares them against the live outputs.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_WB, MemtoReg_WB;
  logic [31:0] ReadData_WB, ALUOut_WB;
  logic [4:0]  WriteReg_WB, ReadReg1, ReadReg2, dbg_addr;
  logic [31:0] ReadData1, ReadData2, WriteData_WB, dbg_data, wb_count;

  int errors = 0;
  int checks = 0;

  typedef enum logic [2:0] {SIG_RD1, SIG_RD2, SIG_WD, SIG_DBG, SIG_CNT} sig_e;
  typedef struct {
    sig_e        sig;
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];

  wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .RegWrite_WB  (RegWrite_WB),
    .MemtoReg_WB  (MemtoReg_WB),
    .ReadData_WB  (ReadData_WB),
    .ALUOut_WB    (ALUOut_WB),
    .WriteReg_WB  (WriteReg_WB),
    .ReadReg1     (ReadReg1),
    .ReadReg2     (ReadReg2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .WriteData_WB (WriteData_WB),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .wb_count     (wb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_sig(input sig_e sig, input string name, input logic [31:0] exp);
    exp_t e;
    e.sig  = sig;
    e.name = name;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are sampled on the falling edge, mid-way between commits.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.sig)
        SIG_RD1: act = ReadData1;
        SIG_RD2: act = ReadData2;
        SIG_WD:  act = WriteData_WB;
        SIG_DBG: act = dbg_data;
        default: act = wb_count;
      endcase
      check(e.name, act, e.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic we, input logic m2r, input logic [31:0] rdata,
                          input logic [31:0] alu, input logic [4:0] wreg);
    RegWrite_WB = we;
    MemtoReg_WB = m2r;
    ReadData_WB = rdata;
    ALUOut_WB   = alu;
    WriteReg_WB = wreg;
  endtask

  task automatic drive_rd(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d);
    ReadReg1 = r1;
    ReadReg2 = r2;
    dbg_addr = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    drive_rd(5'd5, 5'd3, 5'd9);
    tick();

    // Reset state
    expect_sig(SIG_RD1, "reset_rd1", 32'h0);
    expect_sig(SIG_RD2, "reset_rd2", 32'h0);
    expect_sig(SIG_DBG, "reset_dbg", 32'h0);
    expect_sig(SIG_CNT, "reset_cnt", 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Write ALU result to r3, bypass visible before the edge
    drive_wr(1'b1, 1'b0, 32'hBAD0_BAD0, 32'hDEAD_BEEF, 5'd3);
    drive_rd(5'd0, 5'd3, 5'd0);
    expect_sig(SIG_WD,  "wr3_wd",     32'hDEAD_BEEF);
    expect_sig(SIG_RD2, "wr3_bypass", 32'hDEAD_BEEF);
    expect_sig(SIG_RD1, "wr3_rd1_r0", 32'h0);
    tick();
    drive_wr(1'b0, 1'b0, 32'hBAD0_BAD0, 32'h0, 5'd0);
    drive_rd(5'd0, 5'd3, 5'd3);
    expect_sig(SIG_RD2, "rd3_stored", 32'hDEAD_BEEF);
    expect_sig(SIG_DBG, "dbg3_stored", 32'hDEAD_BEEF);
    expect_sig(SIG_CNT, "cnt_after_wr3", 32'd1);
    tick();

    // Load data selected, both ports bypass to r9
    drive_wr(1'b1, 1'b1, 32'h0000_00AA, 32'h1234_5678, 5'd9);
    drive_rd(5'd9, 5'd9, 5'd3);
    expect_sig(SIG_RD1, "mux_bypass_rd1", 32'h0000_00AA);
    expect_sig(SIG_RD2, "mux_bypass_rd2", 32'h0000_00AA);
    expect_sig(SIG_WD,  "mux_wd_load",    32'h0000_00AA);
    expect_sig(SIG_DBG, "mux_dbg3",       32'hDEAD_BEEF);
    tick();
    drive_wr(1'b0, 1'b0, 32'h0000_00AA, 32'h1234_5678, 5'd9);
    expect_sig(SIG_RD1, "rd9_stored", 32'h0000_00AA);
    expect_sig(SIG_WD,  "mux_wd_alu_no_we", 32'h1234_5678);
    expect_sig(SIG_CNT, "cnt_after_wr9", 32'd2);
    tick();

    // Register 0 write is discarded, not bypassed, not counted
    drive_wr(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
    drive_rd(5'd0, 5'd0, 5'd0);
    expect_sig(SIG_RD1, "r0_no_bypass_rd1", 32'h0);
    expect_sig(SIG_RD2, "r0_no_bypass_rd2", 32'h0);
    expect_sig(SIG_DBG, "r0_no_bypass_dbg", 32'h0);
    expect_sig(SIG_WD,  "r0_wd", 32'hFFFF_FFFF);
    tick();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    expect_sig(SIG_RD1, "r0_after_rd1", 32'h0);
    expect_sig(SIG_DBG, "r0_after_dbg", 32'h0);
    expect_sig(SIG_CNT, "r0_cnt_unchanged", 32'd2);
    tick();

    // Disabled write leaves the old value in r4
    drive_wr(1'b1, 1'b0, 32'h0, 32'h11, 5'd4);
    tick();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h55, 5'd4);
    drive_rd(5'd4, 5'd3, 5'd4);
    expect_sig(SIG_RD1, "dis_before_edge", 32'h11);
    expect_sig(SIG_DBG, "dis_dbg_before",  32'h11);
    tick();
    expect_sig(SIG_RD1, "dis_after_edge", 32'h11);
    expect_sig(SIG_CNT, "dis_cnt", 32'd3);
    tick();

    // Bypass on port 1 only; port 2 reads its own stored register
    drive_wr(1'b1, 1'b0, 32'h0, 32'h77, 5'd4);
    drive_rd(5'd4, 5'd3, 5'd9);
    expect_sig(SIG_RD1, "split_rd1_bypass", 32'h77);
    expect_sig(SIG_RD2, "split_rd2_stored", 32'hDEAD_BEEF);
    expect_sig(SIG_DBG, "split_dbg_stored", 32'h0000_00AA);
    tick();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    expect_sig(SIG_RD1, "rd4_overwritten", 32'h77);
    expect_sig(SIG_CNT, "cnt_after_split", 32'd4);
    tick();

    // Counter wrap
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    expect_sig(SIG_CNT, "cnt_forced", 32'hFFFF_FFFF);
    tick();
    drive_wr(1'b1, 1'b0, 32'h0, 32'hCAFE_0007, 5'd7);
    tick();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    drive_rd(5'd7, 5'd0, 5'd7);
    expect_sig(SIG_CNT, "cnt_wrap", 32'h0);
    expect_sig(SIG_RD1, "wrap_write_landed", 32'hCAFE_0007);
    tick();

    // Build regs[5]=0x1234 and wb_count=7, then reset mid-stream
    for (int i = 0; i < 7; i++) begin
      if (i == 0) drive_wr(1'b1, 1'b0, 32'h0, 32'h1234, 5'd5);
      else        drive_wr(1'b1, 1'b0, 32'h0, 32'(i), 5'(10 + i));
      tick();
    end
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    drive_rd(5'd5, 5'd16, 5'd11);
    expect_sig(SIG_RD1, "pre_rst_rd5", 32'h1234);
    expect_sig(SIG_RD2, "pre_rst_rd16", 32'd6);
    expect_sig(SIG_CNT, "pre_rst_cnt", 32'd7);
    tick();
    drive_wr(1'b1, 1'b0, 32'h0, 32'h999, 5'd6);
    drive_rd(5'd5, 5'd6, 5'd11);
    #2;
    rst = 1'b1;
    expect_sig(SIG_RD1, "rst_async_rd5", 32'h0);
    expect_sig(SIG_CNT, "rst_async_cnt", 32'h0);
    expect_sig(SIG_DBG, "rst_async_dbg11", 32'h0);
    expect_sig(SIG_RD2, "rst_bypass_rd6", 32'h999);
    tick();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    expect_sig(SIG_RD2, "rst_no_commit_rd6", 32'h0);
    expect_sig(SIG_CNT, "rst_no_commit_cnt", 32'h0);
    tick();
    rst = 1'b0;
    drive_rd(5'd11, 5'd3, 5'd7);
    expect_sig(SIG_RD1, "post_rst_rd11", 32'h0);
    expect_sig(SIG_RD2, "post_rst_rd3", 32'h0);
    expect_sig(SIG_DBG, "post_rst_dbg7", 32'h0);
    tick();
    drive_wr(1'b1, 1'b0, 32'h0, 32'hABC, 5'd5);
    tick();
    drive_wr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    drive_rd(5'd5, 5'd0, 5'd5);
    expect_sig(SIG_RD1, "resume_rd5", 32'hABC);
    expect_sig(SIG_CNT, "resume_cnt", 32'd1);
    tick();

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
